// File: rtl/reg_bus_arbiter_if.sv
// Requester and register-block signals of reg_bus_arbiter.
// The arbiter uses the slave modport; the environment (requesters and register
// block) uses the master modport.
interface reg_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // requester side
  logic [1:0]        iREQ;
  logic [1:0]        iWR;
  logic [ADDR_W-1:0] iADR0;
  logic [ADDR_W-1:0] iADR1;
  logic [DATA_W-1:0] iWDAT0;
  logic [DATA_W-1:0] iWDAT1;
  logic [1:0]        oACK;
  logic [DATA_W-1:0] oRDAT;
  logic              oERR;
  logic [1:0]        oGNT;
  logic              oBUSY;
  // register-block side
  logic [ADDR_W-1:0] oPWADR;
  logic [DATA_W-1:0] oPWDAT;
  logic              oPWRTE;
  logic [ADDR_W-1:0] oPRADR;
  logic [DATA_W-1:0] iPRDAT;
  logic              iPERR;
  // error statistics
  logic              iERRCLR;
  logic [7:0]        oERRCNT;

  modport slave (
    input  iREQ, iWR, iADR0, iADR1, iWDAT0, iWDAT1, iPRDAT, iPERR, iERRCLR,
    output oACK, oRDAT, oERR, oGNT, oBUSY, oPWADR, oPWDAT, oPWRTE, oPRADR, oERRCNT
  );

  modport master (
    output iREQ, iWR, iADR0, iADR1, iWDAT0, iWDAT1, iPRDAT, iPERR, iERRCLR,
    input  oACK, oRDAT, oERR, oGNT, oBUSY, oPWADR, oPWDAT, oPWRTE, oPRADR, oERRCNT
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares one register-block port between two requesters
// (0 = AXI4-Lite side, 1 = local sequencer/debug). Round-robin on ties, one
// transaction in flight, fixed read latency RD_LAT (1..4) cycles.
module reg_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  reg_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // WAIT cycle count at which read data is sampled (ISSUE counts as cycle 0)
  localparam logic [2:0] LP_WAIT_LAST = 3'(RD_LAT - 1);

  state_t            r_state;
  logic              r_last;     // index of the last requester served
  logic              r_wr;
  logic [2:0]        r_cnt;
  logic [1:0]        r_gnt;
  logic              r_busy;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdat;
  logic              r_err;
  logic [ADDR_W-1:0] r_pwadr;
  logic [DATA_W-1:0] r_pwdat;
  logic              r_pwrte;
  logic [ADDR_W-1:0] r_pradr;
  logic [7:0]        r_errcnt;

  logic              w_pick;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_wdat;
  logic              w_wr;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_pick = 1'b0;
    if (bus.iREQ == 2'b11) begin
      w_pick = ~r_last;
    end else if (bus.iREQ[1]) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
  end

  assign w_adr  = w_pick ? bus.iADR1  : bus.iADR0;
  assign w_wdat = w_pick ? bus.iWDAT1 : bus.iWDAT0;
  assign w_wr   = w_pick ? bus.iWR[1] : bus.iWR[0];

  // Transaction FSM; every output is registered on the transition into the state that shows it
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_wr     <= 1'b0;
      r_cnt    <= 3'd0;
      r_gnt    <= 2'b00;
      r_busy   <= 1'b0;
      r_ack    <= 2'b00;
      r_rdat   <= '0;
      r_err    <= 1'b0;
      r_pwadr  <= '0;
      r_pwdat  <= '0;
      r_pwrte  <= 1'b0;
      r_pradr  <= '0;
      r_errcnt <= 8'd0;
    end else begin
      // clear has priority over counting the error of the transaction completing now
      if (bus.iERRCLR) begin
        r_errcnt <= 8'd0;
      end else if ((r_state == S_DONE) && r_err && (r_errcnt != 8'hFF)) begin
        r_errcnt <= r_errcnt + 8'd1;
      end else begin
        r_errcnt <= r_errcnt;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.iREQ != 2'b00) begin
            r_wr   <= w_wr;
            r_gnt  <= w_pick ? 2'b10 : 2'b01;
            r_busy <= 1'b1;
            if (w_wr) begin
              r_pwrte <= 1'b1;
              r_pwadr <= w_adr;
              r_pwdat <= w_wdat;
            end else begin
              r_pradr <= w_adr;
            end
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_pwrte <= 1'b0;
          r_pwadr <= '0;
          r_pwdat <= '0;
          if (r_wr) begin
            r_err   <= bus.iPERR;
            r_rdat  <= '0;
            r_ack   <= r_gnt;
            r_state <= S_DONE;
          end else if (RD_LAT == 1) begin
            r_rdat  <= bus.iPRDAT;
            r_err   <= bus.iPERR;
            r_ack   <= r_gnt;
            r_pradr <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 3'd1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == LP_WAIT_LAST) begin
            r_rdat  <= bus.iPRDAT;
            r_err   <= bus.iPERR;
            r_ack   <= r_gnt;
            r_pradr <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_last  <= r_gnt[1];
          r_ack   <= 2'b00;
          r_rdat  <= '0;
          r_err   <= 1'b0;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack   <= 2'b00;
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_pwrte <= 1'b0;
          r_pwadr <= '0;
          r_pwdat <= '0;
          r_pradr <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The write strobe is suppressed while reset is asserted so an aborted
  // transaction never reaches the register block.
  assign bus.oPWRTE  = r_pwrte & ~iRST;
  assign bus.oPWADR  = r_pwadr;
  assign bus.oPWDAT  = r_pwdat;
  assign bus.oPRADR  = r_pradr;
  assign bus.oACK    = r_ack;
  assign bus.oRDAT   = r_rdat;
  assign bus.oERR    = r_err;
  assign bus.oGNT    = r_gnt;
  assign bus.oBUSY   = r_busy;
  assign bus.oERRCNT = r_errcnt;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomised bench for reg_bus_arbiter with a transaction-level reference model.
// The model tracks the transaction in flight by its start cycle and derives each
// output from the cycle offset into that transaction.
module tb_reg_bus_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int PH_B   = 1500;   // continuous-write / error-saturation phase start
  localparam int N_CYC  = 2700;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // sampled register-block responses, indexed by cycle
  logic [31:0] prdat_h [0:4095];
  logic        perr_h  [0:4095];

  // reference model of the transaction in flight
  bit          m_busy = 1'b0;
  int          m_s = 0;
  int          m_len = 0;
  bit          m_g = 1'b0;
  bit          m_last = 1'b1;
  bit          m_wr = 1'b0;
  logic [7:0]  m_adr = 8'd0;
  logic [31:0] m_wdat = 32'd0;
  int          m_cnt = 0;

  // requester state
  bit          pend [2];
  logic        rq   [2];
  logic        wr_d [2];
  logic [7:0]  adr_d [2];
  logic [31:0] wdat_d [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    int  off;
    bit  act, ack_now, rst_v, clr, clr_done, e_err;
    int  sat_acks;
    logic [1:0]  e_gnt;
    logic [31:0] e_rdat;

    clr_done = 1'b0;
    sat_acks = 0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; rq[k] = 1'b0; wr_d[k] = 1'b0; adr_d[k] = 8'd0; wdat_d[k] = 32'd0;
    end
    bus.iREQ = 2'b00; bus.iWR = 2'b00; bus.iADR0 = 8'd0; bus.iADR1 = 8'd0;
    bus.iWDAT0 = 32'd0; bus.iWDAT1 = 32'd0; bus.iPRDAT = 32'd0; bus.iPERR = 1'b0;
    bus.iERRCLR = 1'b0;

    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk);
      cyc     = c;
      act     = m_busy;
      off     = c - m_s;
      ack_now = act && (off == m_len);

      // reset: initial, at phase B start, sometimes in a write ISSUE cycle, rarely at random
      if (c < 4 || c == PH_B) rst_v = 1'b1;
      else if (c < PH_B)
        rst_v = (act && m_wr && off == 1 && $urandom_range(0, 19) == 0) ||
                ($urandom_range(0, 299) == 0);
      else rst_v = 1'b0;
      rst = rst_v;

      // requesters
      for (int k = 0; k < 2; k++) begin
        if (ack_now && (m_g == 1'(k))) pend[k] = 1'b0;
        if (!pend[k]) begin
          if (c >= PH_B || $urandom_range(0, 2) == 0) begin
            pend[k] = 1'b1; rq[k] = 1'b1;
            wr_d[k] = (c >= PH_B) ? 1'b1 : 1'($urandom_range(0, 1));
          end else begin
            rq[k] = 1'b0; wr_d[k] = 1'($urandom_range(0, 1));
          end
          adr_d[k]  = 8'($urandom_range(0, 255));
          wdat_d[k] = $urandom;
        end else if (act && (m_g == 1'(k)) && c < PH_B && $urandom_range(0, 3) == 0) begin
          // payload already latched: scramble it, possibly dropping the request
          rq[k]     = 1'($urandom_range(0, 1));
          wr_d[k]   = 1'($urandom_range(0, 1));
          adr_d[k]  = 8'($urandom_range(0, 255));
          wdat_d[k] = $urandom;
        end
      end
      bus.iREQ   = {rq[1], rq[0]};
      bus.iWR    = {wr_d[1], wr_d[0]};
      bus.iADR0  = adr_d[0];  bus.iADR1  = adr_d[1];
      bus.iWDAT0 = wdat_d[0]; bus.iWDAT1 = wdat_d[1];

      // error clear: random in phase A, once at a saturated error ack in phase B
      if (c < PH_B) clr = ($urandom_range(0, 19) == 0);
      else if (!clr_done && m_cnt == 255 && ack_now && sat_acks >= 3) begin
        clr = 1'b1; clr_done = 1'b1;
      end else clr = 1'b0;
      bus.iERRCLR = clr;

      // register-block response
      prdat_h[c]  = $urandom;
      perr_h[c]   = (c >= PH_B) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.iPRDAT  = prdat_h[c];
      bus.iPERR   = perr_h[c];

      #1;
      e_gnt = act ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      check_eq("gnt",   32'(bus.oGNT), 32'(e_gnt));
      check_eq("busy",  32'(bus.oBUSY), 32'(act));
      check_eq("pwrte", 32'(bus.oPWRTE), 32'(act && m_wr && off == 1 && !rst_v));
      check_eq("pwadr", 32'(bus.oPWADR), (act && m_wr && off == 1) ? 32'(m_adr) : 32'd0);
      check_eq("pwdat", bus.oPWDAT, (act && m_wr && off == 1) ? m_wdat : 32'd0);
      check_eq("pradr", 32'(bus.oPRADR),
               (act && !m_wr && off >= 1 && off <= RD_LAT) ? 32'(m_adr) : 32'd0);
      check_eq("ack",   32'(bus.oACK), ack_now ? 32'(e_gnt) : 32'd0);
      check_eq("errcnt", 32'(bus.oERRCNT), 32'(m_cnt));
      e_err = 1'b0;
      if (ack_now) begin
        e_err  = m_wr ? perr_h[m_s + 1] : perr_h[m_s + RD_LAT];
        e_rdat = m_wr ? 32'd0 : prdat_h[m_s + RD_LAT];
        check_eq("rdat", bus.oRDAT, e_rdat);
        check_eq("err",  32'(bus.oERR), 32'(e_err));
      end

      // advance the model to the next cycle
      if (rst_v) begin
        m_busy = 1'b0; m_last = 1'b1; m_cnt = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
      end else begin
        if (clr) m_cnt = 0;
        else if (ack_now && e_err && m_cnt < 255) m_cnt++;
        if (ack_now && c >= PH_B && m_cnt == 255) sat_acks++;
        if (ack_now) begin
          m_busy = 1'b0; m_last = m_g;
        end else if (!act && (rq[0] || rq[1])) begin
          m_g    = (rq[0] && rq[1]) ? ~m_last : rq[1];
          m_wr   = wr_d[m_g];
          m_adr  = adr_d[m_g];
          m_wdat = wdat_d[m_g];
          m_s    = c;
          m_len  = m_wr ? 2 : RD_LAT + 1;
          m_busy = 1'b1;
        end
      end
    end

    check_eq("sat_reached", 32'(clr_done), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
